// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I execute/write-back stage: opcodes, funct codes,
// the ALU operation set and the stage FSM encoding.
package riscv_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_t;

    // alt selects SUB over ADD and SRA over SRL; ignored for the other fn3 codes.
    function automatic alu_op_t fn3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32I integer ALU; shifts use the low five bits of b.
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        // NOTE: a default assignment up front keeps every path driven, so no latch is inferred.
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_execute_wb.sv
// RV32I execute/write-back stage: decode, operand select, registered write-back.
// Define RISCV_MUL_EN to add the iterative shift-add MUL (stalls via in_ready).
module riscv_execute_wb
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [2:0]            fn3,
    input  logic [6:0]            fn7,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       rout1,
    input  logic [XLEN-1:0]       rout2,
    output logic [XLEN-1:0]       write_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    alu_op_t         alu_op;
    logic            op_legal;
    logic            is_mul;
    logic            accept;
    logic            unused_fields;

    assign opcode        = instruction[6:0];
    assign imm           = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign accept        = in_valid & in_ready;
    assign unused_fields = ^instruction[19:7];

    always_comb begin
        op_legal = 1'b0;
        is_mul   = 1'b0;
        alu_op   = ALU_ADD;
        op_b     = rout2;
        case (opcode)
            OP_R: begin
                if (fn7 == F7_BASE) begin
                    op_legal = 1'b1;
                    alu_op   = fn3_to_op(fn3, 1'b0);
                end else if (fn7 == F7_ALT && (fn3 == F3_ADD || fn3 == F3_SR)) begin
                    op_legal = 1'b1;
                    alu_op   = fn3_to_op(fn3, 1'b1);
                end
`ifdef RISCV_MUL_EN
                else if (fn7 == F7_MULDIV && fn3 == F3_ADD) begin
                    is_mul = 1'b1;
                end
`endif
            end
            OP_I: begin
                // Immediate ops have no SUBI; only the right shift honours bit 30.
                op_legal = 1'b1;
                op_b     = imm;
                alu_op   = fn3_to_op(fn3, (fn3 == F3_SR) && instruction[30]);
            end
            default: ;
        endcase
    end

    riscv_alu #(.XLEN(XLEN)) u_alu (
        .a      (rout1),
        .b      (op_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    logic                  mul_done;
    logic [XLEN-1:0]       mul_result;
    logic [REG_ADDR_W-1:0] mul_rd;

`ifdef RISCV_MUL_EN
    state_t          state;
    logic [4:0]      mul_cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_step;

    assign acc_step   = acc + (mplier[0] ? mcand : '0);
    assign in_ready   = (state == ST_IDLE);
    assign mul_done   = (state == ST_MUL_BUSY) && (mul_cnt == 5'd31);
    assign mul_result = acc_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (accept && is_mul) state <= ST_MUL_BUSY;
                ST_MUL_BUSY: if (mul_cnt == 5'd31) state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the multiplier datapath is deliberately not reset; it is only observed while
    // the FSM is busy, and reset returning the FSM to IDLE is enough to discard it.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand   <= rout1;
            mplier  <= rout2;
            acc     <= '0;
            mul_cnt <= '0;
            mul_rd  <= rd;
        end else if (state == ST_MUL_BUSY) begin
            acc     <= acc_step;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 5'd1;
        end
    end
`else
    assign in_ready   = 1'b1;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_rd     = '0;
`endif

    // An ALU accept and a MUL completion never coincide: the stage is stalled while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_data <= '0;
            reg_write  <= 1'b0;
            wb_rd      <= '0;
            illegal    <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            illegal   <= accept && !op_legal && !is_mul;
            if (accept && op_legal && rd != '0) begin
                reg_write  <= 1'b1;
                write_data <= alu_result;
                wb_rd      <= rd;
            end else if (mul_done && mul_rd != '0) begin
                reg_write  <= 1'b1;
                write_data <= mul_result;
                wb_rd      <= mul_rd;
            end
        end
    end

endmodule

// File: tb/tb_riscv_execute_wb.sv
// Self-checking bench for riscv_execute_wb: directed literal cases, then randomized
// traffic compared every cycle against an instruction-level reference model.
module tb_riscv_execute_wb;

`ifdef RISCV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [4:0]  rd;
    logic [31:0] rout1;
    logic [31:0] rout2;
    logic [31:0] write_data;
    logic        reg_write;
    logic [4:0]  wb_rd;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    riscv_execute_wb dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .fn3         (fn3),
        .fn7         (fn7),
        .rd          (rd),
        .rout1       (rout1),
        .rout2       (rout2),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .wb_rd       (wb_rd),
        .illegal     (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference semantics of one instruction. kind: 0 = ALU write, 1 = illegal, 2 = multiply.
    function automatic void ref_op(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] rb, output int kind,
                                   output logic [31:0] res);
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] b;
        logic        alt;
        op   = ins[6:0];
        f7   = ins[31:25];
        f3   = ins[14:12];
        b    = rb;
        alt  = 1'b0;
        kind = 1;
        res  = '0;
        if (op == R_OP) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                kind = 0;
                alt  = f7[5];
            end else if (MUL_EN && f7 == 7'h01 && f3 == 3'd0) begin
                kind = 2;
                res  = a * rb;
            end
        end else if (op == I_OP) begin
            kind = 0;
            b    = {{20{ins[31]}}, ins[31:20]};
            alt  = (f3 == 3'd5) && ins[30];
        end
        if (kind == 0) begin
            case (f3)
                3'd0: res = alt ? a - b : a + b;
                3'd1: res = a << b[4:0];
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end
    endfunction

    // Behavioural model: expected outputs for the cycle following each rising edge.
    int          m_busy = 0;
    logic [31:0] m_wd, m_mul_res;
    logic [4:0]  m_rd, m_mul_rd;
    logic        m_rw, m_ill, m_ready;

    always @(posedge clk) begin
        int          kind;
        logic [31:0] res;
        m_rw  = 1'b0;
        m_ill = 1'b0;
        if (reset) begin
            m_wd   = '0;
            m_rd   = '0;
            m_busy = 0;
        end else if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0 && m_mul_rd != 0) begin
                m_rw = 1'b1;
                m_wd = m_mul_res;
                m_rd = m_mul_rd;
            end
        end else if (in_valid) begin
            ref_op(instruction, rout1, rout2, kind, res);
            if (kind == 0 && rd != 0) begin
                m_rw = 1'b1;
                m_wd = res;
                m_rd = rd;
            end else if (kind == 1) begin
                m_ill = 1'b1;
            end else if (kind == 2) begin
                m_busy    = 32;
                m_mul_res = res;
                m_mul_rd  = rd;
            end
        end
        m_ready = (m_busy == 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            check("model reg_write", {31'd0, reg_write}, {31'd0, m_rw});
            check("model illegal", {31'd0, illegal}, {31'd0, m_ill});
            check("model write_data", write_data, m_wd);
            check("model wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
        end
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] d);
        return {f7, 5'd2, 5'd1, f3, d, R_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                           input logic [4:0] d);
        return {imm, 5'd1, f3, d, I_OP};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instruction = ins;
        fn3         = ins[14:12];
        fn7         = ins[31:25];
        rd          = ins[11:7];
        rout1       = a;
        rout2       = b;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random();
        logic [31:0] ins;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  d;
        logic [11:0] imm;
        int          p;
        d  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        f3 = 3'($urandom);
        p  = $urandom_range(0, 99);
        if (p < 50) begin
            p = $urandom_range(0, 9);
            if (p < 6) f7 = 7'h00;
            else if (p < 8) begin
                f7 = 7'h20;
                f3 = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd5;
            end else if (p < 9) begin
                f7 = 7'h01;
                if ($urandom_range(0, 1) != 0) f3 = 3'd0;
            end else f7 = 7'($urandom) | 7'h40;
            ins = {f7, 5'($urandom), 5'($urandom), f3, d, R_OP};
        end else if (p < 85) begin
            imm = 12'($urandom);
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            ins = {imm, 5'($urandom), f3, d, I_OP};
        end else begin
            ins = $urandom;
            if (ins[6:0] == R_OP || ins[6:0] == I_OP) ins[6:0] = 7'b0000011;
        end
        instruction = ins;
        fn3         = ins[14:12];
        fn7         = ins[31:25];
        rd          = ins[11:7];
        rout1       = pick_val();
        rout2       = pick_val();
        in_valid    = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        int          kind;
        logic [31:0] res;
        int          lows;
        int          pulses;

        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = '0;
        fn3         = '0;
        fn7         = '0;
        rd          = '0;
        rout1       = '0;
        rout2       = '0;
        repeat (2) @(negedge clk);

        check("reset reg_write", {31'd0, reg_write}, 32'd0);
        check("reset write_data", write_data, 32'd0);
        check("reset wb_rd", {27'd0, wb_rd}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        reset  = 1'b0;
        chk_en = 1'b1;

        ref_op(r_type(7'h20, 3'd0, 5'd4), 32'd3, 32'd5, kind, res);
        check("ref SUB", res, 32'hFFFF_FFFE);
        ref_op(i_type(12'h404, 3'd5, 5'd5), 32'h8000_0000, 32'd0, kind, res);
        check("ref SRAI", res, 32'hF800_0000);

        issue(r_type(7'h00, 3'd0, 5'd3), 32'd5, 32'd7);
        check("ADD reg_write", {31'd0, reg_write}, 32'd1);
        check("ADD write_data", write_data, 32'd12);
        check("ADD wb_rd", {27'd0, wb_rd}, 32'd3);
        @(negedge clk);
        check("ADD pulse ends", {31'd0, reg_write}, 32'd0);
        check("ADD data holds", write_data, 32'd12);

        issue(r_type(7'h20, 3'd0, 5'd4), 32'd3, 32'd5);
        check("SUB write_data", write_data, 32'hFFFF_FFFE);

        issue(i_type(12'h404, 3'd5, 5'd5), 32'h8000_0000, 32'd0);
        check("SRAI write_data", write_data, 32'hF800_0000);

        issue(r_type(7'h00, 3'd3, 5'd6), 32'hFFFF_FFFF, 32'd1);
        check("SLTU reg_write", {31'd0, reg_write}, 32'd1);
        check("SLTU write_data", write_data, 32'd0);

        issue(i_type(12'hFFF, 3'd0, 5'd0), 32'd9, 32'd0);
        check("x0 reg_write", {31'd0, reg_write}, 32'd0);
        check("x0 illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        check("x0 reg_write later", {31'd0, reg_write}, 32'd0);

        issue({25'd0, 7'b0000011}, 32'd1, 32'd2);
        check("LOAD illegal", {31'd0, illegal}, 32'd1);
        check("LOAD reg_write", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        check("LOAD illegal ends", {31'd0, illegal}, 32'd0);

        issue(r_type(7'h01, 3'd0, 5'd7), 32'd6, 32'd7);
        if (MUL_EN) begin
            lows = 0;
            for (int k = 0; k < 40 && !reg_write; k++) begin
                if (!in_ready) lows++;
                @(negedge clk);
            end
            check("MUL reg_write", {31'd0, reg_write}, 32'd1);
            check("MUL stall cycles", 32'(lows), 32'd32);
            check("MUL write_data", write_data, 32'd42);
            check("MUL wb_rd", {27'd0, wb_rd}, 32'd7);
            @(negedge clk);

            issue(r_type(7'h01, 3'd0, 5'd8), 32'd11, 32'd13);
            repeat (10) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort in_ready", {31'd0, in_ready}, 32'd1);
            pulses = 0;
            for (int k = 0; k < 40; k++) begin
                if (reg_write) pulses++;
                @(negedge clk);
            end
            check("abort no write", 32'(pulses), 32'd0);
        end else begin
            check("MUL illegal", {31'd0, illegal}, 32'd1);
            check("MUL reg_write", {31'd0, reg_write}, 32'd0);
            @(negedge clk);
        end

        for (int c = 0; c < 3000; c++) begin
            drive_random();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
